// File: rtl/music_stream_fetcher_pkg.sv
// Shared types and helpers for the flash audio stream fetcher.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  function automatic int samples_per_word(input int data_w, input int audio_w);
    return data_w / audio_w;
  endfunction

endpackage

// File: rtl/music_stream_fetcher_word_fifo.sv
// Prefetch word FIFO: power-of-two depth, synchronous flush, occupancy count.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/music_stream_fetcher.sv
// Streams flash words over Avalon-MM into a prefetch FIFO and emits one unpacked sample per tick.
module music_stream_fetcher
  import music_pkg::*;
#(
  parameter int ADDR_WIDTH       = 23,
  parameter int DATA_WIDTH       = 32,
  parameter int BYTEENABLE_WIDTH = 4,
  parameter int AUDIO_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk_50,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic                        restart,
  input  logic                        forward,
  input  logic                        loop_en,
  input  logic                        paused,
  input  logic [ADDR_WIDTH-1:0]       start_addr,
  input  logic [ADDR_WIDTH-1:0]       end_addr,
  input  logic                        flash_mem_waitrequest,
  input  logic                        flash_mem_readdatavalid,
  input  logic [DATA_WIDTH-1:0]       flash_mem_readdata,
  output logic                        flash_mem_read,
  output logic [ADDR_WIDTH-1:0]       flash_mem_address,
  output logic [BYTEENABLE_WIDTH-1:0] flash_mem_byteenable,
  output logic [AUDIO_DATA_WIDTH-1:0] audio_data,
  output logic                        audio_strobe,
  output logic                        underrun,
  output logic                        done,
  output logic [1:0]                  fetch_state
);

  // Avalon read: flash_mem_read holds with a stable address until a cycle with
  // waitrequest low accepts it; exactly one read is in flight, returned by one readdatavalid.

  localparam int N  = samples_per_word(DATA_WIDTH, AUDIO_DATA_WIDTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  if (DATA_WIDTH % AUDIO_DATA_WIDTH != 0) begin : g_width_check
    $error("DATA_WIDTH must be a multiple of AUDIO_DATA_WIDTH");
  end

  fetch_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0]    fetch_addr;
  logic                     fetch_done;
  logic                     drain;
  logic                     cfg_fwd, cfg_loop;
  logic [ADDR_WIDTH-1:0]    cfg_start, cfg_end;
  logic [IW-1:0]            idx;
  logic [CW-1:0]            fifo_count;
  logic [DATA_WIDTH-1:0]    fifo_head;
  logic                     fifo_push, fifo_pop, fifo_empty;
  logic                     tick_go, last_idx;
  logic [AUDIO_DATA_WIDTH-1:0] head_samples [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign head_samples[g] = fifo_head[g*AUDIO_DATA_WIDTH +: AUDIO_DATA_WIDTH];
  end

  assign fifo_empty = (fifo_count == '0);
  assign tick_go    = sample_tick & ~paused & ~restart;
  assign last_idx   = cfg_fwd ? (idx == LAST_IDX) : (idx == '0);
  assign fifo_push  = (state == WAIT) & flash_mem_readdatavalid & ~drain & ~restart;
  assign fifo_pop   = tick_go & ~fifo_empty & last_idx;

  word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk_50),
    .rst       (rst),
    .flush     (restart),
    .push      (fifo_push),
    .push_data (flash_mem_readdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // In IDLE nothing is outstanding, so occupancy alone bounds the prefetch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!restart && !fetch_done && (fifo_count < DEPTH_C)) state_nxt = REQ;
      REQ:     if (!flash_mem_waitrequest) state_nxt = WAIT;
      WAIT:    if (flash_mem_readdatavalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign flash_mem_read       = (state == REQ);
  assign flash_mem_byteenable = '1;
  assign fetch_state          = state;

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      flash_mem_address <= '0;
      fetch_addr        <= '0;
      fetch_done        <= 1'b1;
      drain             <= 1'b0;
      cfg_fwd           <= 1'b1;
      cfg_loop          <= 1'b1;
      cfg_start         <= '0;
      cfg_end           <= '0;
    end else begin
      if (state == IDLE && state_nxt == REQ) flash_mem_address <= fetch_addr;
      if (restart) begin
        cfg_fwd    <= forward;
        cfg_loop   <= loop_en;
        cfg_start  <= start_addr;
        cfg_end    <= end_addr;
        fetch_addr <= forward ? start_addr : end_addr;
        fetch_done <= 1'b0;
        // A read already issued belongs to the old clip and must be swallowed.
        drain      <= (state == REQ) || (state == WAIT && !flash_mem_readdatavalid);
      end else if (state == WAIT && flash_mem_readdatavalid) begin
        if (drain) begin
          drain <= 1'b0;
        end else if (cfg_fwd) begin
          if (fetch_addr == cfg_end) begin
            if (cfg_loop) fetch_addr <= cfg_start;
            else          fetch_done <= 1'b1;
          end else begin
            fetch_addr <= fetch_addr + 1'b1;
          end
        end else begin
          if (fetch_addr == cfg_start) begin
            if (cfg_loop) fetch_addr <= cfg_end;
            else          fetch_done <= 1'b1;
          end else begin
            fetch_addr <= fetch_addr - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      audio_data   <= '0;
      audio_strobe <= 1'b0;
      underrun     <= 1'b0;
      done         <= 1'b0;
      idx          <= '0;
    end else begin
      audio_strobe <= 1'b0;
      underrun     <= 1'b0;
      if (restart) begin
        done <= 1'b0;
        idx  <= forward ? '0 : LAST_IDX;
      end else if (tick_go) begin
        if (!fifo_empty) begin
          audio_data   <= head_samples[idx];
          audio_strobe <= 1'b1;
          if (last_idx) begin
            idx <= cfg_fwd ? '0 : LAST_IDX;
            // fetch_done set means no word can still arrive behind this one.
            if (fetch_done && fifo_count == ONE_C) done <= 1'b1;
          end else begin
            idx <= cfg_fwd ? idx + 1'b1 : idx - 1'b1;
          end
        end else if (!done) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule
